// File: rtl/lsu_mem_subsys_pkg.sv
// Shared encodings and helpers for the load/store memory subsystem.
package lsu_mem_subsys_pkg;

  // Access size encodings carried on req_size
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Byte lanes covered by an access of the given size, before lane shifting
  function automatic logic [7:0] size_lanes(input logic [1:0] sz);
    logic [7:0] lanes;
    case (sz)
      SZ_B:    lanes = 8'h01;
      SZ_H:    lanes = 8'h03;
      SZ_W:    lanes = 8'h0f;
      default: lanes = 8'hff;
    endcase
    return lanes;
  endfunction

  // Low address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    logic [2:0] m;
    case (sz)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_subsys_ram.sv
// Single-port byte-enabled synchronous RAM with RD_LAT output register stages.
module ram_be_sp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     i_cs,
  input  logic                     i_we,
  input  logic [XLEN/8-1:0]        i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [XLEN-1:0]          i_wdata,
  output logic [XLEN-1:0]          o_rdata
);

  localparam int unsigned NB = XLEN / 8;

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_q1;

  // Byte-masked write; contents are never reset
  always_ff @(posedge clk) begin
    if (i_cs && i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // First read stage; holds its value until the next read
  always_ff @(posedge clk) begin
    if (i_cs && !i_we) r_q1 <= r_mem[i_addr];
  end

  if (RD_LAT > 1) begin : g_lat2
    logic [XLEN-1:0] r_q2;
    // Extra output stage for the two-cycle read configuration
    always_ff @(posedge clk) begin
      r_q2 <= r_q1;
    end
    assign o_rdata = r_q2;
  end else begin : g_lat1
    assign o_rdata = r_q1;
  end

endmodule

// File: rtl/lsu_mem_subsys.sv
// Load/store controller with on-chip byte-enabled RAM, one request in flight.
module lsu_mem_subsys
  import lsu_mem_subsys_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_read,
  input  logic            req_write,
  input  logic            req_usign,
  input  logic [1:0]      req_size,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned IW   = $clog2(DEPTH);

  state_e r_state, w_state_nx;
  logic   r_req_ready, w_req_ready_nx;
  logic   r_resp_valid, w_resp_valid_nx;
  logic   r_resp_err, w_resp_err_nx;
  logic   r_ld_sel, w_ld_sel_nx;

  logic            r_write, r_usign;
  logic [1:0]      r_size;
  logic [OFFW-1:0] r_off;
  logic [IW-1:0]   r_idx;
  logic [XLEN-1:0] r_wdata;

  logic            w_accept, w_rw, w_misal, w_badsz, w_oor, w_fault;
  logic            w_cs, w_we, w_ram_we;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_wdata_sh, w_ram_q, w_sh, w_ld;

  // Request decode and fault classification at accept time
  assign w_accept = req_valid & r_req_ready;
  assign w_rw     = req_read | req_write;
  assign w_misal  = (req_addr[2:0] & align_mask(req_size)) != 3'b000;
  assign w_badsz  = 32'(req_size) > OFFW;
  assign w_oor    = (req_addr >> (OFFW + IW)) != '0;
  assign w_fault  = (req_read & req_write) | (w_rw & (w_misal | w_badsz | w_oor));

  // Control state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_ld_sel     <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_req_ready  <= w_req_ready_nx;
      r_resp_valid <= w_resp_valid_nx;
      r_resp_err   <= w_resp_err_nx;
      r_ld_sel     <= w_ld_sel_nx;
    end
  end

  // Capture request fields on accept
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_usign <= req_usign;
      r_size  <= req_size;
      r_off   <= req_addr[OFFW-1:0];
      r_idx   <= req_addr[OFFW +: IW];
      r_wdata <= req_wdata;
    end
  end

  // Next-state, next-output and RAM strobes
  always_comb begin
    w_state_nx      = r_state;
    w_resp_valid_nx = r_resp_valid;
    w_resp_err_nx   = r_resp_err;
    w_ld_sel_nx     = r_ld_sel;
    w_cs            = 1'b0;
    w_we            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_fault || !w_rw) begin
            w_state_nx      = ST_RESP;
            w_resp_valid_nx = 1'b1;
            w_resp_err_nx   = w_fault;
            w_ld_sel_nx     = 1'b0;
          end else begin
            w_state_nx = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        w_cs = 1'b1;
        w_we = r_write;
        if (r_write) begin
          w_state_nx      = ST_RESP;
          w_resp_valid_nx = 1'b1;
          w_resp_err_nx   = 1'b0;
          w_ld_sel_nx     = 1'b0;
        end else if (RD_LAT > 1) begin
          w_state_nx = ST_WAIT;
        end else begin
          w_state_nx      = ST_RESP;
          w_resp_valid_nx = 1'b1;
          w_resp_err_nx   = 1'b0;
          w_ld_sel_nx     = 1'b1;
        end
      end
      ST_WAIT: begin
        w_state_nx      = ST_RESP;
        w_resp_valid_nx = 1'b1;
        w_resp_err_nx   = 1'b0;
        w_ld_sel_nx     = 1'b1;
      end
      default: begin
        if (resp_ready) begin
          w_state_nx      = ST_IDLE;
          w_resp_valid_nx = 1'b0;
          w_resp_err_nx   = 1'b0;
          w_ld_sel_nx     = 1'b0;
        end
      end
    endcase
    w_req_ready_nx = (w_state_nx == ST_IDLE);
  end

  // Store steering; a reset edge must never commit a write
  assign w_be       = NB'(size_lanes(r_size)) << r_off;
  assign w_wdata_sh = r_wdata << {r_off, 3'b000};
  assign w_ram_we   = w_we & ~rst;

  ram_be_sp #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk     (clk),
    .i_cs    (w_cs),
    .i_we    (w_ram_we),
    .i_be    (w_be),
    .i_addr  (r_idx),
    .i_wdata (w_wdata_sh),
    .o_rdata (w_ram_q)
  );

  // Load extraction from the held RAM output word
  assign w_sh = w_ram_q >> {r_off, 3'b000};

  always_comb begin
    w_ld = w_sh;
    case (r_size)
      SZ_B:    w_ld = r_usign ? XLEN'(w_sh[7:0])  : XLEN'($signed(w_sh[7:0]));
      SZ_H:    w_ld = r_usign ? XLEN'(w_sh[15:0]) : XLEN'($signed(w_sh[15:0]));
      SZ_W:    w_ld = r_usign ? XLEN'(w_sh[31:0]) : XLEN'($signed(w_sh[31:0]));
      default: w_ld = w_sh;
    endcase
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_ld_sel ? w_ld : '0;

endmodule

// File: doc/lsu_mem_subsys.md
Name: lsu_mem_subsys

Overview:
Parametrised successor to the core's memory unit: a load/store controller plus an on-chip byte-enabled single-port RAM, behind a valid/ready request channel and a new valid/ready response channel.
- Adds configurable data width, depth and RAM read latency.
- Byte-lane steering and write-mask generation move inside the block; the AGU sends only size, address and raw store data.
- Sits between the AGU and writeback; one outstanding request at a time.

Parameters:
XLEN, 32, data width in bits; 32 or 64.
AW, 32, request address width in bits.
DEPTH, 256, RAM depth in XLEN-wide words; power of two.
RD_LAT, 1, RAM read latency in cycles; 1 or 2.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request valid.
req_ready  out  1  request ready.
req_read  in  1  load.
req_write  in  1  store.
req_usign  in  1  load is zero-extended (1) or sign-extended (0).
req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
req_addr  in  AW  byte address.
req_wdata  in  XLEN  store data, right-aligned (LSBs).
resp_valid  out  1  response valid.
resp_ready  in  1  response accepted.
resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
resp_err  out  1  access faulted.

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs reset as follows: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE. RAM contents are not reset.
- Accept: a request is taken on edge E0 when req_valid & req_ready. All request fields are latched at E0. req_ready=1 only in IDLE and is a registered output.
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - IDLE -> ACCESS on accept with no fault.
  - IDLE -> RESP on accept with a fault (err=1, rdata=0). resp_valid is visible in cycle E0+1 and the RAM is not touched.
  - ACCESS: RAM chip-select asserted for one cycle. Store: write with byte enables, -> RESP. Load: -> WAIT if RD_LAT=2, else -> RESP capturing data.
  - WAIT: one cycle, -> RESP capturing data.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready; then -> IDLE.
- Latency:
  - Store: resp_valid first visible in cycle E0+2.
  - Load: resp_valid first visible in cycle E0+1+RD_LAT.
  - Turnaround: after the resp handshake, req_ready returns in the next cycle. There is no same-cycle re-accept.
- Faults (resp_err=1):
  - Misaligned: addr[size-1:0] != 0.
  - size=3 when XLEN=32.
  - Out of range: word index addr >> log2(XLEN/8) >= DEPTH.
  - req_read & req_write both set.
  - No read and no write: no-op completing in cycle E0+1 with err=0, rdata=0.
- Store steering:
  - Lane offset = addr[log2(XLEN/8)-1:0].
  - Byte enables = ((1<<(1<<size))-1) << offset.
  - Data is shifted left by 8*offset.
- Load extraction: shift the RAM word right by 8*offset, mask to the access size, then sign- or zero-extend to XLEN per req_usign. A full-width load ignores req_usign.
- Reset mid-operation: the RAM write enable is gated by ~rst, so a reset asserted in the ACCESS cycle suppresses the write. Any in-flight response is discarded and no resp_valid is produced.
- Inputs are ignored while req_ready=0.

Decomposition:
- Shared defines file additions: size encodings (SZ_B/SZ_H/SZ_W/SZ_D) and FSM state encoding (2-bit).
- One sub-module, ram_be_sp: single-port synchronous RAM, XLEN wide, DEPTH deep.
  - Ports: cs, we, byte-enable vector, word address, wdata, rdata.
  - RD_LAT output register stages.
  - No reset on contents.

Test Plan:
- Reset, then release -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- XLEN=32, RD_LAT=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> store resp at E0+2; load resp at E0+2 with rdata=0xDEADBEEF, err=0. Repeat with RD_LAT=2 -> load resp at E0+3.
- SB 0x80 @0x13, then:
  - LB @0x13 -> 0xFFFFFF80.
  - LBU @0x13 -> 0x00000080.
  - LW @0x10 -> 0x80ADBEEF.
  - LH @0x12 -> 0xFFFF80AD.
- LH @0x11 -> err=1, rdata=0, resp at E0+1, memory unchanged. SW @0x400 (word index 256) -> err=1. size=3 at XLEN=32 -> err=1.
- Hold resp_ready=0 for 5 cycles with req_valid=1 -> resp_valid, rdata and err stable; req_ready=0; no new accept. Release -> req_ready=1 the following cycle.
- Assert rst during the ACCESS cycle of SW 0x12345678 @0x20 -> no response; a subsequent LW @0x20 returns the prior contents.
